// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with a start/busy/done handshake.
// Single-cycle ops (add, sub, logic, pass-B, compares, shifts) finish on the
// start edge. MUL (shift-add) and DIVU/REMU (restoring division) iterate one
// bit per clock and finish WIDTH edges after the start edge.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start            request, sampled only while busy = 0
//   SrcA, SrcB       operands, sampled with start
//   ALUControl       4-bit opcode, sampled with start
//   ALUResult        registered result, held until the next completion
//   zero             registered, 1 if the captured SrcA equals the captured SrcB
//   sgn              ALUResult[WIDTH-1]
//   busy             multi-cycle operation in progress
//   done             one-cycle pulse, ALUResult and zero valid
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// MUL   | one shift-add step per edge
// DIV   | one restoring-division step per edge
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero,
    output logic             sgn,
    output logic             busy,
    output logic             done
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   result_q, result_n;
    logic               zero_q, zero_n;
    logic               done_q, done_n;
    logic [3:0]         op_q, op_n;
    logic               eq_q, eq_n;
    // The operand registers are shared by MUL and DIV:
    //   a_q   multiplicand | dividend, refilled with quotient bits from the LSB
    //   b_q   multiplier   | divisor
    //   acc_q accumulator  | partial remainder
    logic [WIDTH-1:0]   a_q, a_n;
    logic [WIDTH-1:0]   b_q, b_n;
    logic [WIDTH-1:0]   acc_q, acc_n;
    logic [SHW-1:0]     cnt_q, cnt_n;

    logic [WIDTH-1:0]   mul_sum;
    logic [WIDTH:0]     rem_ext;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic               last_iter;

    function automatic logic [WIDTH-1:0] single_op(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [SHW-1:0] sh;
        logic [WIDTH-1:0] res;
        sh = b[SHW-1:0];
        case (op)
            4'b0000: res = a + b;
            4'b0001: res = a - b;
            4'b0010: res = a & b;
            4'b0011: res = a | b;
            4'b0100: res = b;
            4'b0101: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0110: res = {{(WIDTH-1){1'b0}}, (a < b)};
            4'b0111: res = a ^ b;
            4'b1000: res = a << sh;
            4'b1001: res = a >> sh;
            4'b1010: res = $signed(a) >>> sh;
            default: res = '0;
        endcase
        return res;
    endfunction

    always_comb begin
        mul_sum   = acc_q + (b_q[0] ? a_q : '0);
        // The shifted partial remainder needs one extra bit before the compare.
        rem_ext   = {acc_q, a_q[WIDTH-1]};
        rem_ge    = (rem_ext >= {1'b0, b_q});
        // When rem_ge holds the difference fits in WIDTH bits, so modulo
        // arithmetic on the low bits is exact.
        rem_next  = rem_ge ? (rem_ext[WIDTH-1:0] - b_q) : rem_ext[WIDTH-1:0];
        quo_next  = {a_q[WIDTH-2:0], rem_ge};
        last_iter = (cnt_q == SHW'(WIDTH - 1));
    end

    always_comb begin
        state_next = state;
        result_n   = result_q;
        zero_n     = zero_q;
        done_n     = 1'b0;
        op_n       = op_q;
        eq_n       = eq_q;
        a_n        = a_q;
        b_n        = b_q;
        acc_n      = acc_q;
        cnt_n      = cnt_q;

        case (state)
            IDLE: begin
                if (start) begin
                    op_n = ALUControl;
                    eq_n = (SrcA == SrcB);
                    if (ALUControl == 4'b1011 || ALUControl == 4'b1100 ||
                        ALUControl == 4'b1101) begin
                        a_n        = SrcA;
                        b_n        = SrcB;
                        acc_n      = '0;
                        cnt_n      = '0;
                        state_next = (ALUControl == 4'b1011) ? MUL : DIV;
                    end else begin
                        result_n = single_op(ALUControl, SrcA, SrcB);
                        zero_n   = (SrcA == SrcB);
                        done_n   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_n = mul_sum;
                a_n   = a_q << 1;
                b_n   = b_q >> 1;
                cnt_n = cnt_q + SHW'(1);
                if (last_iter) begin
                    result_n   = mul_sum;
                    zero_n     = eq_q;
                    done_n     = 1'b1;
                    state_next = IDLE;
                end
            end
            DIV: begin
                acc_n = rem_next;
                a_n   = quo_next;
                cnt_n = cnt_q + SHW'(1);
                if (last_iter) begin
                    result_n   = (op_q == 4'b1101) ? rem_next : quo_next;
                    zero_n     = eq_q;
                    done_n     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            op_q     <= '0;
            eq_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state    <= state_next;
            result_q <= result_n;
            zero_q   <= zero_n;
            done_q   <= done_n;
            op_q     <= op_n;
            eq_q     <= eq_n;
            a_q      <= a_n;
            b_q      <= b_n;
            acc_q    <= acc_n;
            cnt_q    <= cnt_n;
        end
    end

    assign ALUResult = result_q;
    assign zero      = zero_q;
    assign sgn       = result_q[WIDTH-1];
    assign busy      = (state != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;
    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        zero;
    logic        sgn;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int lat;
    int bcnt;
    int seen;

    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                           OP_OR = 4'b0011, OP_PASSB = 4'b0100, OP_SLT = 4'b0101,
                           OP_SLTU = 4'b0110, OP_XOR = 4'b0111, OP_SLL = 4'b1000,
                           OP_SRL = 4'b1001, OP_SRA = 4'b1010, OP_MUL = 4'b1011,
                           OP_DIVU = 4'b1100, OP_REMU = 4'b1101, OP_RSV = 4'b1110;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .zero       (zero),
        .sgn        (sgn),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one operation and returns at the falling edge where done is seen.
    // lat counts clock edges after the start edge before done became visible.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat_o, output int bcnt_o);
        @(negedge clk);
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        start      = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat_o  = 0;
        bcnt_o = 0;
        while (!done && lat_o < 100) begin
            if (busy) bcnt_o++;
            @(negedge clk);
            lat_o++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; SrcA = '0; SrcB = '0; ALUControl = '0;
        #1;
        chk("rst_result", ALUResult, 32'h0);
        chk("rst_zero", 32'(zero), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        run_op(OP_ADD, 32'd7, -32'sd3, lat, bcnt);
        chk("add_res", ALUResult, 32'd4);
        chk("add_lat", 32'(lat), 32'd0);
        chk("add_sgn", 32'(sgn), 32'd0);
        @(negedge clk);
        chk("add_done_pulse", 32'(done), 32'd0);

        run_op(OP_SUB, 32'd3, 32'd7, lat, bcnt);
        chk("sub_res", ALUResult, 32'hFFFF_FFFC);
        chk("sub_sgn", 32'(sgn), 32'd1);
        run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, lat, bcnt);
        chk("slt_res", ALUResult, 32'd1);
        run_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, lat, bcnt);
        chk("sltu_res", ALUResult, 32'd0);
        run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, lat, bcnt);
        chk("and_res", ALUResult, 32'h00F0_1200);
        run_op(OP_OR, 32'hF0F0_1234, 32'h0FF0_FF00, lat, bcnt);
        chk("or_res", ALUResult, 32'hFFF0_FF34);
        run_op(OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, lat, bcnt);
        chk("xor_res", ALUResult, 32'hFF00_ED34);
        run_op(OP_PASSB, 32'h1111_1111, 32'hCAFE_0001, lat, bcnt);
        chk("passb_res", ALUResult, 32'hCAFE_0001);
        run_op(OP_RSV, 32'h1111_1111, 32'h2222_2222, lat, bcnt);
        chk("rsv_res", ALUResult, 32'h0);
        run_op(OP_ADD, 32'd9, 32'd9, lat, bcnt);
        chk("add_eq_zero", 32'(zero), 32'd1);
        chk("add_eq_res", ALUResult, 32'd18);

        run_op(OP_SLL, 32'h8000_0001, 32'd4, lat, bcnt);
        chk("sll_res", ALUResult, 32'h0000_0010);
        run_op(OP_SRL, 32'h8000_0001, 32'd4, lat, bcnt);
        chk("srl_res", ALUResult, 32'h0800_0000);
        run_op(OP_SRA, 32'h8000_0001, 32'd4, lat, bcnt);
        chk("sra_res", ALUResult, 32'hF800_0000);
        run_op(OP_SLL, 32'h8000_0001, 32'd36, lat, bcnt);
        chk("sll36_res", ALUResult, 32'h0000_0010);
        run_op(OP_SRL, 32'h8000_0001, 32'd36, lat, bcnt);
        chk("srl36_res", ALUResult, 32'h0800_0000);
        run_op(OP_SRA, 32'h8000_0001, 32'd36, lat, bcnt);
        chk("sra36_res", ALUResult, 32'hF800_0000);

        run_op(OP_MUL, 32'd12345, 32'd678, lat, bcnt);
        chk("mul_res", ALUResult, 32'd8369910);
        chk("mul_lat", 32'(lat), 32'd32);
        chk("mul_busy_cycles", 32'(bcnt), 32'd32);
        chk("mul_busy_at_done", 32'(busy), 32'd0);
        chk("mul_zero", 32'(zero), 32'd0);
        // Start a single-cycle op in the done cycle: accepted, done again next cycle.
        ALUControl = OP_ADD; SrcA = 32'd5; SrcB = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_res", ALUResult, 32'd11);
        @(negedge clk);
        chk("b2b_done_drop", 32'(done), 32'd0);

        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        chk("mul_ones_res", ALUResult, 32'h0000_0001);
        chk("mul_ones_zero", 32'(zero), 32'd1);

        run_op(OP_DIVU, 32'd100, 32'd7, lat, bcnt);
        chk("divu_res", ALUResult, 32'd14);
        chk("divu_lat", 32'(lat), 32'd32);
        run_op(OP_REMU, 32'd100, 32'd7, lat, bcnt);
        chk("remu_res", ALUResult, 32'd2);
        run_op(OP_DIVU, 32'd5, 32'd0, lat, bcnt);
        chk("divu0_res", ALUResult, 32'hFFFF_FFFF);
        chk("divu0_lat", 32'(lat), 32'd32);
        run_op(OP_REMU, 32'd5, 32'd0, lat, bcnt);
        chk("remu0_res", ALUResult, 32'd5);
        run_op(OP_DIVU, 32'd9, 32'd9, lat, bcnt);
        chk("divu_eq_res", ALUResult, 32'd1);
        chk("divu_eq_zero", 32'(zero), 32'd1);
        run_op(OP_REMU, 32'hDEAD_BEEF, 32'h0001_0000, lat, bcnt);
        chk("remu_big_res", ALUResult, 32'h0000_BEEF);

        // Start while busy is ignored; changing inputs mid-op has no effect.
        @(negedge clk);
        ALUControl = OP_MUL; SrcA = 32'd12345; SrcB = 32'd678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        repeat (3) @(negedge clk);
        lat += 3;
        ALUControl = OP_ADD; SrcA = 32'd1; SrcB = 32'd1; start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_done", 32'(done), 32'd0);
        ALUControl = OP_SUB; SrcA = 32'h5555_5555;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("ign_mul_res", ALUResult, 32'd8369910);
        chk("ign_mul_lat", 32'(lat), 32'd32);

        // Reset partway through a divide aborts it without a done pulse.
        @(negedge clk);
        ALUControl = OP_DIVU; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_result", ALUResult, 32'h0);
        chk("midrst_zero", 32'(zero), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        chk("midrst_hold", ALUResult, 32'h0);
        run_op(OP_ADD, 32'd1, 32'd1, lat, bcnt);
        chk("post_rst_add", ALUResult, 32'd2);
        chk("post_rst_lat", 32'(lat), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
